rob_commit: RTL and testbench
=============================

ROB_COMMIT -- requirements
Module: rob_commit

Interface
REQ-001 Parameter ROB_SIZE, default `ROB_SIZE, number of ROB slots; tags are 1..ROB_SIZE and 0 means "no tag".
REQ-002 Parameter LSQ_SIZE, default `LSQ_SIZE, number of LSQ slots.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port rob_count  input  int  number of valid ROB entries.
REQ-006 Port head_entry  input  rob_entry  ROB slot at rob_head-1, muxed externally.
REQ-007 Port lsq_head_entry  input  lsq_entry  oldest LSQ entry; supplies store address and data.
REQ-008 Port map_tag_rd  input  int  map_table[head_entry.rd].tag, muxed externally.
REQ-009 Port mem_ack  input  1  data memory has accepted the store.
REQ-010 Port rob_head  output  int  current head tag.
REQ-011 Port rob_decrement / lsq_decrement  output  1 each  one-cycle pops.
REQ-012 Port reg_we, reg_addr (Register), reg_data (MemoryWord)  output  architectural write.
REQ-013 Port map_clear, map_clear_reg (Register)  output  clear the map-table tag for that register.
REQ-014 Port store_req, store_addr, store_data (MemoryWord), store_type  output  memory store request.
REQ-015 Port halt  output  1  ecall retired.
REQ-016 Port retired_count  output  32  total instructions retired.

Function
REQ-017 The FSM SHALL have the states COMMIT, STORE_WAIT and HALTED.
REQ-018 In COMMIT with rob_count>0 and head_entry.ready=1 (or ctrl_bits.memwr=1), the head SHALL retire in the same cycle; otherwise all pulse outputs SHALL be 0.
REQ-019 Retire SHALL assert rob_decrement for exactly one cycle; rob_head SHALL advance on the next edge, wrapping from ROB_SIZE to 1.
REQ-020 At most one entry SHALL retire per cycle.
REQ-021 Register write:
  - Condition: ctrl_bits.regwr=1 and rd!=0.
  - Outputs: reg_we=1, reg_addr=rd, reg_data=head_entry.value.
  - rd=0: no write is performed.
REQ-022 On a register write, map_clear SHALL be 1 with map_clear_reg=rd only when map_tag_rd==rob_head; a younger mapping SHALL be preserved.
REQ-023 A load (memtoreg) SHALL also assert lsq_decrement in its retire cycle.
REQ-024 Store head in COMMIT:
  - Drive store_req=1, store_addr/store_data from lsq_head_entry, and store_type=ctrl_bits.memory_type.
  - mem_ack=1 in the same cycle: retire now with rob_decrement=lsq_decrement=1.
  - mem_ack=0: go to STORE_WAIT.
REQ-025 In STORE_WAIT, store_req and its payload SHALL stay asserted and stable until mem_ack=1; that cycle SHALL retire (rob_decrement=lsq_decrement=1) and return to COMMIT.
REQ-026 An unsupported head SHALL retire with no register, map, memory or LSQ side effects.
REQ-027 An ecall head SHALL retire and move to HALTED, asserting halt from the next cycle.
REQ-028 In HALTED, no outputs other than halt and rob_head SHALL change, and no further retirement SHALL occur.
REQ-029 A jump head (ucjump or cjump) with regwr SHALL write head_entry.value (the link value) like any ALU op.
REQ-030 retired_count SHALL increment by 1 on every retire and wrap at 2^32.
REQ-031 rob_count=0 SHALL never retire, even if head_entry.ready=1.

Reset
REQ-032 While reset=0, asynchronously: state=COMMIT, rob_head=1, retired_count=0, halt=0, and all pulse, request and data outputs=0.
REQ-033 A reset during STORE_WAIT SHALL drop store_req immediately; no retire is counted.

Structure
REQ-034 rob_entry, lsq_entry, control_bits, MemoryWord, Register, `ROB_SIZE and `LSQ_SIZE come from the shared package; the commit_state enum SHALL be added there.
REQ-035 The block is a single module with no sub-modules; the head-wrap increment MAY be a local function.

Verification
REQ-036 Head tag 1: add with ready, rd=5, value=0x2A, map_tag_rd=1 -> same cycle reg_we=1, reg_addr=5, reg_data=0x2A, map_clear=1; next cycle rob_head=2.
REQ-037 Same as REQ-036 but map_tag_rd=3 -> reg_we=1, map_clear=0.
REQ-038 Store head, mem_ack low for 3 cycles then high -> store_req high for 4 cycles with a stable payload; rob_decrement=lsq_decrement=1 only in the ack cycle.
REQ-039 ROB_SIZE=4, retire 5 ready entries back-to-back -> rob_head sequence 1,2,3,4,1,2; retired_count=5.
REQ-040 Ecall at head, followed by ready entries -> halt=1 from the next cycle, no further rob_decrement, retired_count frozen.
REQ-041 reset=0 mid STORE_WAIT -> store_req=0 at once, rob_head=1, state COMMIT after release.

Source files
------------

// File: rtl/rob_commit_pkg.sv
// Shared types for the commit stage: ROB/LSQ entries, control bits and the commit FSM states.
`ifndef ROB_SIZE
`define ROB_SIZE 8
`endif
`ifndef LSQ_SIZE
`define LSQ_SIZE 8
`endif

package rob_commit_pkg;

    typedef logic [31:0] MemoryWord;
    typedef logic [4:0]  Register;

    typedef enum logic [1:0] {
        MEM_BYTE,
        MEM_HALF,
        MEM_WORD
    } memory_type_t;

    typedef struct packed {
        logic         regwr;
        logic         memtoreg;
        logic         memwr;
        logic         ucjump;
        logic         cjump;
        logic         ecall;
        logic         unsupported;
        memory_type_t memory_type;
    } control_bits;

    typedef struct packed {
        logic        ready;
        control_bits ctrl_bits;
        Register     rd;
        MemoryWord   value;
    } rob_entry;

    typedef struct packed {
        MemoryWord address;
        MemoryWord data;
    } lsq_entry;

    typedef enum logic [1:0] {
        COMMIT,
        STORE_WAIT,
        HALTED
    } commit_state;

endpackage

// File: rtl/rob_commit_if.sv
// Store request channel between the commit stage and data memory.
interface rob_commit_if;
    import rob_commit_pkg::*;

    logic         store_req;
    MemoryWord    store_addr;
    MemoryWord    store_data;
    memory_type_t store_type;
    logic         mem_ack;

    modport master (
        output store_req,
        output store_addr,
        output store_data,
        output store_type,
        input  mem_ack
    );

    modport slave (
        input  store_req,
        input  store_addr,
        input  store_data,
        input  store_type,
        output mem_ack
    );

endinterface

// File: rtl/rob_commit.sv
// In-order retirement: retires at most one ROB head per cycle, performing its
// architectural register write, map-table clear, or memory store.
module rob_commit
    import rob_commit_pkg::*;
#(
    parameter int ROB_SIZE = `ROB_SIZE,
    parameter int LSQ_SIZE = `LSQ_SIZE
) (
    input  logic         clk,
    input  logic         reset,
    input  int           rob_count,
    input  rob_entry     head_entry,
    input  lsq_entry     lsq_head_entry,
    input  int           map_tag_rd,
    output int           rob_head,
    output logic         rob_decrement,
    output logic         lsq_decrement,
    output logic         reg_we,
    output Register      reg_addr,
    output MemoryWord    reg_data,
    output logic         map_clear,
    output Register      map_clear_reg,
    output logic         halt,
    output logic [31:0]  retired_count,
    rob_commit_if.master mem
);

    commit_state  state, next_state;
    control_bits  ctrl;
    logic         head_valid;
    logic         retire;
    logic         capture_store;
    logic         store_req;
    MemoryWord    store_addr, store_data;
    memory_type_t store_type;
    MemoryWord    held_addr, held_data;
    memory_type_t held_type;

    // Jump kind and LSQ depth do not change how an entry retires.
    logic unused_cfg;
    assign unused_cfg = ^{ctrl.ucjump, ctrl.cjump, LSQ_SIZE};

    function automatic int next_tag(input int tag);
        return (tag >= ROB_SIZE) ? 1 : tag + 1;
    endfunction

    assign ctrl       = head_entry.ctrl_bits;
    assign head_valid = (rob_count > 0) && (head_entry.ready || ctrl.memwr);

    // Outputs are gated by reset so they drop asynchronously, not just at the next edge.
    always_comb begin
        next_state    = state;
        retire        = 1'b0;
        capture_store = 1'b0;
        lsq_decrement = 1'b0;
        reg_we        = 1'b0;
        reg_addr      = '0;
        reg_data      = '0;
        map_clear     = 1'b0;
        map_clear_reg = '0;
        store_req     = 1'b0;
        store_addr    = '0;
        store_data    = '0;
        store_type    = MEM_BYTE;
        if (reset) begin
            case (state)
                COMMIT: begin
                    if (head_valid) begin
                        if (ctrl.unsupported) begin
                            retire = 1'b1;
                        end else if (ctrl.ecall) begin
                            retire     = 1'b1;
                            next_state = HALTED;
                        end else if (ctrl.memwr) begin
                            store_req  = 1'b1;
                            store_addr = lsq_head_entry.address;
                            store_data = lsq_head_entry.data;
                            store_type = ctrl.memory_type;
                            if (mem.mem_ack) begin
                                retire        = 1'b1;
                                lsq_decrement = 1'b1;
                            end else begin
                                capture_store = 1'b1;
                                next_state    = STORE_WAIT;
                            end
                        end else begin
                            retire        = 1'b1;
                            lsq_decrement = ctrl.memtoreg;
                            if (ctrl.regwr && head_entry.rd != '0) begin
                                reg_we   = 1'b1;
                                reg_addr = head_entry.rd;
                                reg_data = head_entry.value;
                                // A younger producer may already own this register's mapping.
                                if (map_tag_rd == rob_head) begin
                                    map_clear     = 1'b1;
                                    map_clear_reg = head_entry.rd;
                                end
                            end
                        end
                    end
                end
                STORE_WAIT: begin
                    store_req  = 1'b1;
                    store_addr = held_addr;
                    store_data = held_data;
                    store_type = held_type;
                    if (mem.mem_ack) begin
                        retire        = 1'b1;
                        lsq_decrement = 1'b1;
                        next_state    = COMMIT;
                    end
                end
                HALTED: begin
                end
                default: next_state = COMMIT;
            endcase
        end
    end

    // Store payload is latched so memory sees a stable request while it stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= COMMIT;
            rob_head      <= 1;
            retired_count <= '0;
            held_addr     <= '0;
            held_data     <= '0;
            held_type     <= MEM_BYTE;
        end else begin
            state <= next_state;
            if (retire) begin
                rob_head      <= next_tag(rob_head);
                retired_count <= retired_count + 32'd1;
            end
            if (capture_store) begin
                held_addr <= lsq_head_entry.address;
                held_data <= lsq_head_entry.data;
                held_type <= ctrl.memory_type;
            end
        end
    end

    assign rob_decrement  = retire;
    assign halt           = (state == HALTED);
    assign mem.store_req  = store_req;
    assign mem.store_addr = store_addr;
    assign mem.store_data = store_data;
    assign mem.store_type = store_type;

endmodule

// File: tb/tb_rob_commit.sv
// Scoreboard bench for rob_commit: a retirement model predicts each cycle's outputs,
// a monitor compares them at the falling edge.
module tb_rob_commit;
    import rob_commit_pkg::*;

    localparam int ROB_SZ = 4;

    typedef struct packed {
        logic        rob_dec;
        logic        lsq_dec;
        logic        reg_we;
        Register     reg_addr;
        MemoryWord   reg_data;
        logic        map_clear;
        Register     map_clear_reg;
        logic        store_req;
        MemoryWord   store_addr;
        MemoryWord   store_data;
        logic [1:0]  store_type;
        logic        halt;
        logic [31:0] head;
        logic [31:0] retired;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset;
    int          rob_count;
    rob_entry    head_entry;
    lsq_entry    lsq_head_entry;
    int          map_tag_rd;
    int          rob_head;
    logic        rob_decrement, lsq_decrement, reg_we, map_clear, halt;
    Register     reg_addr, map_clear_reg;
    MemoryWord   reg_data;
    logic [31:0] retired_count;

    rob_commit_if mem_if ();

    rob_commit #(.ROB_SIZE(ROB_SZ), .LSQ_SIZE(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .rob_count      (rob_count),
        .head_entry     (head_entry),
        .lsq_head_entry (lsq_head_entry),
        .map_tag_rd     (map_tag_rd),
        .rob_head       (rob_head),
        .rob_decrement  (rob_decrement),
        .lsq_decrement  (lsq_decrement),
        .reg_we         (reg_we),
        .reg_addr       (reg_addr),
        .reg_data       (reg_data),
        .map_clear      (map_clear),
        .map_clear_reg  (map_clear_reg),
        .halt           (halt),
        .retired_count  (retired_count),
        .mem            (mem_if.master)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    obs_t exp_q[$];

    // Reference model state: retirement described as head tag, count, halt and pending store.
    int          m_head = 1;
    int unsigned m_retired = 0;
    bit          m_halted = 0;
    bit          m_pending = 0;
    MemoryWord   m_saddr, m_sdata;
    logic [1:0]  m_stype;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, want %0h", name, $time, actual, expected);
        end
    endtask

    function automatic rob_entry makeEntry(input int kind, input Register rd, input MemoryWord val, input logic ready);
        rob_entry r;
        r = '0;
        r.ready = ready;
        r.rd    = rd;
        r.value = val;
        r.ctrl_bits.memory_type = memory_type_t'($urandom_range(0, 2));
        case (kind)
            0: r.ctrl_bits.regwr = 1'b1;
            1: begin r.ctrl_bits.regwr = 1'b1; r.ctrl_bits.memtoreg = 1'b1; end
            2: r.ctrl_bits.memwr = 1'b1;
            3: begin r.ctrl_bits.ucjump = 1'b1; r.ctrl_bits.regwr = 1'b1; end
            4: r.ctrl_bits.cjump = 1'b1;
            5: begin r.ctrl_bits.unsupported = 1'b1; r.ctrl_bits.regwr = 1'b1; r.ctrl_bits.memtoreg = 1'b1; end
            default: r.ctrl_bits.ecall = 1'b1;
        endcase
        return r;
    endfunction

    function automatic lsq_entry randLsq();
        lsq_entry l;
        l.address = $urandom();
        l.data    = $urandom();
        return l;
    endfunction

    task automatic setIdle();
        rob_count      = 0;
        head_entry     = '0;
        lsq_head_entry = '0;
        map_tag_rd     = 0;
        mem_if.mem_ack = 1'b0;
    endtask

    task automatic modelReset();
        m_head    = 1;
        m_retired = 0;
        m_halted  = 0;
        m_pending = 0;
    endtask

    // Drives one cycle of inputs and queues the outputs the model predicts for it.
    task automatic applyStimulus(input int rc, input rob_entry he, input lsq_entry le, input int mtag, input logic ack);
        obs_t        e;
        control_bits c;
        bit          ret, pop;
        @(posedge clk);
        #1;
        rob_count      = rc;
        head_entry     = he;
        lsq_head_entry = le;
        map_tag_rd     = mtag;
        mem_if.mem_ack = ack;
        e = '0;
        e.head    = m_head;
        e.retired = m_retired;
        e.halt    = m_halted;
        c   = he.ctrl_bits;
        ret = 0;
        pop = 0;
        if (m_halted) begin
        end else if (m_pending) begin
            e.store_req  = 1'b1;
            e.store_addr = m_saddr;
            e.store_data = m_sdata;
            e.store_type = m_stype;
            if (ack) begin ret = 1; pop = 1; m_pending = 0; end
        end else if (rc > 0 && (he.ready || c.memwr)) begin
            if (c.unsupported) ret = 1;
            else if (c.ecall) begin ret = 1; m_halted = 1; end
            else if (c.memwr) begin
                e.store_req  = 1'b1;
                e.store_addr = le.address;
                e.store_data = le.data;
                e.store_type = c.memory_type;
                if (ack) begin
                    ret = 1;
                    pop = 1;
                end else begin
                    m_pending = 1;
                    m_saddr = le.address;
                    m_sdata = le.data;
                    m_stype = c.memory_type;
                end
            end else begin
                ret = 1;
                pop = c.memtoreg;
                if (c.regwr && he.rd != 0) begin
                    e.reg_we        = 1'b1;
                    e.reg_addr      = he.rd;
                    e.reg_data      = he.value;
                    e.map_clear     = (mtag == m_head);
                    e.map_clear_reg = he.rd;
                end
            end
        end
        e.rob_dec = ret;
        e.lsq_dec = pop;
        if (ret) begin
            m_head = (m_head % ROB_SZ) + 1;
            m_retired++;
        end
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        obs_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("rob_decrement", rob_decrement, e.rob_dec);
                checkOutput("lsq_decrement", lsq_decrement, e.lsq_dec);
                checkOutput("reg_we", reg_we, e.reg_we);
                if (e.reg_we) begin
                    checkOutput("reg_addr", reg_addr, e.reg_addr);
                    checkOutput("reg_data", reg_data, e.reg_data);
                end
                checkOutput("map_clear", map_clear, e.map_clear);
                if (e.map_clear) checkOutput("map_clear_reg", map_clear_reg, e.map_clear_reg);
                checkOutput("store_req", mem_if.store_req, e.store_req);
                if (e.store_req) begin
                    checkOutput("store_addr", mem_if.store_addr, e.store_addr);
                    checkOutput("store_data", mem_if.store_data, e.store_data);
                    checkOutput("store_type", mem_if.store_type, e.store_type);
                end
                checkOutput("halt", halt, e.halt);
                checkOutput("rob_head", rob_head, e.head);
                checkOutput("retired_count", retired_count, e.retired);
            end
        end
    end

    initial begin : stimulus
        int          rc, k;
        int unsigned frozen;
        reset = 1'b0;
        setIdle();

        // Outputs held quiet during reset even with a retirable head present.
        @(negedge clk);
        rob_count  = 1;
        head_entry = makeEntry(0, 5'd5, 32'h2A, 1'b1);
        map_tag_rd = 1;
        #1;
        checkOutput("rst_rob_decrement", rob_decrement, 0);
        checkOutput("rst_reg_we", reg_we, 0);
        checkOutput("rst_rob_head", rob_head, 1);
        checkOutput("rst_retired_count", retired_count, 0);
        checkOutput("rst_halt", halt, 0);
        head_entry     = makeEntry(2, 5'd0, 32'h0, 1'b1);
        mem_if.mem_ack = 1'b1;
        #1;
        checkOutput("rst_store_req", mem_if.store_req, 0);
        @(negedge clk);
        setIdle();
        reset = 1'b1;

        applyStimulus(1, makeEntry(0, 5'd5, 32'h2A, 1'b1), randLsq(), 1, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("req036_reg_data", reg_data, 32'h2A);
        checkOutput("req036_map_clear", map_clear, 1);
        applyStimulus(1, makeEntry(0, 5'd5, 32'h2A, 1'b1), randLsq(), 3, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("req037_reg_we", reg_we, 1);
        checkOutput("req037_map_clear", map_clear, 0);

        for (int i = 0; i < 4; i++)
            applyStimulus(2, makeEntry(2, 5'd0, 32'h0, 1'b0), randLsq(), 0, (i == 3));

        applyStimulus(1, makeEntry(0, 5'd0, 32'h55, 1'b1), randLsq(), 3, 1'b0);
        applyStimulus(1, makeEntry(1, 5'd7, 32'h77, 1'b1), randLsq(), 1, 1'b0);
        applyStimulus(1, makeEntry(3, 5'd1, 32'h400, 1'b1), randLsq(), 2, 1'b0);
        applyStimulus(1, makeEntry(4, 5'd9, 32'h9, 1'b1), randLsq(), 3, 1'b0);
        applyStimulus(1, makeEntry(5, 5'd9, 32'h9, 1'b1), randLsq(), 4, 1'b1);
        applyStimulus(0, makeEntry(0, 5'd3, 32'h3, 1'b1), randLsq(), 1, 1'b1);
        applyStimulus(2, makeEntry(0, 5'd3, 32'h3, 1'b0), randLsq(), 1, 1'b0);

        // Reset while a store is stalled.
        applyStimulus(1, makeEntry(2, 5'd0, 32'h0, 1'b1), randLsq(), 0, 1'b0);
        applyStimulus(1, makeEntry(2, 5'd0, 32'h0, 1'b1), randLsq(), 0, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("req041_store_req", mem_if.store_req, 0);
        checkOutput("req041_rob_head", rob_head, 1);
        checkOutput("req041_retired", retired_count, 0);
        setIdle();
        @(posedge clk);
        #1;
        checkOutput("req041_store_req_held", mem_if.store_req, 0);
        @(negedge clk);
        reset = 1'b1;
        modelReset();

        for (int i = 0; i < 5; i++)
            applyStimulus(3, makeEntry(0, Register'(i + 1), $urandom(), 1'b1), randLsq(), 0, 1'b0);
        applyStimulus(0, '0, randLsq(), 0, 1'b0);
        @(negedge clk);
        #2;
        checkOutput("req039_rob_head", rob_head, 2);
        checkOutput("req039_retired", retired_count, 5);

        for (int i = 0; i < 400; i++) begin
            rc = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, ROB_SZ));
            k  = $urandom_range(0, 9);
            k  = (k < 3) ? 0 : (k == 3) ? 1 : (k < 6) ? 2 : (k == 6) ? 3 : (k == 7) ? 4 : (k == 8) ? 5 : 0;
            applyStimulus(rc,
                          makeEntry(k, Register'($urandom_range(0, 31)), $urandom(), ($urandom_range(0, 3) != 0)),
                          randLsq(),
                          $urandom_range(0, 1) ? m_head : int'($urandom_range(0, ROB_SZ)),
                          1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 4; i++)
            applyStimulus(1, makeEntry(2, 5'd0, 32'h0, 1'b1), randLsq(), 0, (i == 3));

        applyStimulus(2, makeEntry(6, 5'd0, 32'h0, 1'b1), randLsq(), 0, 1'b0);
        frozen = m_retired;
        for (int i = 0; i < 4; i++)
            applyStimulus(3, makeEntry(0, 5'd4, $urandom(), 1'b1), randLsq(), m_head, 1'b1);
        @(negedge clk);
        #2;
        checkOutput("req040_halt", halt, 1);
        checkOutput("req040_rob_decrement", rob_decrement, 0);
        checkOutput("req040_retired", retired_count, frozen);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d expected cycles left unchecked, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
